fec_frame_sched: RTL and testbench

Frame scheduler for the rate-1/2 convolutional FEC path. Arbitrates round-robin between two requesters that each present a 48-bit payload frame, loads the granted frame into the serializer, starts the encoder, and waits for encoder completion. Captures the 96-bit FEC word into an output register and holds it there under a valid/ready handshake. Sits between the payload sources and the serializer/encoder pair.

---
 rtl/fec_frame_sched.sv | 131 +++++++++++++
 tb/tb_fec_frame_sched.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fec_frame_sched.sv
// fec_frame_sched: round-robin frame scheduler for the rate-1/2 FEC path.
// Grants one of two requesters, loads the frame into the serializer, starts
// the encoder, waits for completion and holds the FEC word under valid/ready.
// Optional feature macro: FEC_SCHED_TIMEOUT_EN (RUN timeout with sticky err).
module fec_frame_sched #(
    parameter int unsigned BITS = 48
`ifdef FEC_SCHED_TIMEOUT_EN
    , parameter int unsigned TIMEOUT = 64
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [BITS-1:0]   data0,
    input  logic [BITS-1:0]   data1,
    output logic              gnt0,
    output logic              gnt1,
    output logic [BITS-1:0]   frame,
    output logic              ser_start,
    output logic              enc_ld,
    input  logic              enc_done,
    input  logic [2*BITS-1:0] fec_in,
    output logic [2*BITS-1:0] fec_out,
    output logic              out_id,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t state;
    logic   id;
    logic   last;
    logic   grant_ok;
    logic   win;

`ifdef FEC_SCHED_TIMEOUT_EN
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CW-1:0] cnt;
`else
    assign err = 1'b0;
`endif

    // A grant needs a pending request and a free (or draining) output slot.
    assign grant_ok = (req0 | req1) & (~out_valid | out_ready);
    // Single requester wins outright; on contention the one not served last wins.
    assign win      = (req0 & req1) ? ~last : req1;

    // Scheduler FSM with registered pulses, frame latch and output slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            id        <= 1'b0;
            last      <= 1'b1;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            ser_start <= 1'b0;
            enc_ld    <= 1'b0;
            frame     <= '0;
            fec_out   <= '0;
            out_id    <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef FEC_SCHED_TIMEOUT_EN
            cnt       <= '0;
            err       <= 1'b0;
`endif
        end else begin
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            ser_start <= 1'b0;
            enc_ld    <= 1'b0;
            // A pop frees the slot; a capture later in this block overrides it.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (grant_ok) begin
                        frame     <= win ? data1 : data0;
                        id        <= win;
                        last      <= win;
                        gnt0      <= ~win;
                        gnt1      <= win;
                        ser_start <= 1'b1;
                        enc_ld    <= 1'b1;
                        busy      <= 1'b1;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
`ifdef FEC_SCHED_TIMEOUT_EN
                    cnt   <= '0;
`endif
                    state <= RUN;
                end
                RUN: begin
`ifdef FEC_SCHED_TIMEOUT_EN
                    cnt <= cnt + CW'(1);
`endif
                    if (enc_done) begin
                        fec_out   <= fec_in;
                        out_id    <= id;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
`ifdef FEC_SCHED_TIMEOUT_EN
                    else if (cnt == CW'(TIMEOUT - 1)) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
`endif
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fec_frame_sched.sv
// Testbench for fec_frame_sched: encoder model plus an output scoreboard.
module tb_fec_frame_sched;

    localparam int unsigned BITS = 48;
    localparam int unsigned W    = 2 * BITS;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req0 = 1'b0, req1 = 1'b0;
    logic [BITS-1:0] data0 = '0, data1 = '0;
    logic            gnt0, gnt1, ser_start, enc_ld;
    logic [BITS-1:0] frame;
    logic            enc_done = 1'b0;
    logic [W-1:0]    fec_in = '0;
    logic [W-1:0]    fec_out;
    logic            out_id, out_valid, busy, err;
    logic            out_ready = 1'b0;

    int checks   = 0;
    int failures = 0;
    logic [W:0] sb_q[$];

    int   enc_lat    = 4;
    bit   force_done = 1'b0;
    int   enc_cnt    = 0;
    logic done_int   = 1'b0;

    always #5 clk = ~clk;

    fec_frame_sched dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .data0(data0), .data1(data1), .gnt0(gnt0), .gnt1(gnt1),
        .frame(frame), .ser_start(ser_start), .enc_ld(enc_ld),
        .enc_done(enc_done), .fec_in(fec_in), .fec_out(fec_out),
        .out_id(out_id), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .err(err)
    );

    function automatic logic [W-1:0] enc_fn(input logic [BITS-1:0] d);
        logic [BITS-1:0] r;
        r = {d[23:0], d[47:24]};
        return {d ^ 48'h0F0F_3C3C_5A5A, r};
    endfunction

    // Encoder model: done level rises enc_lat cycles after enc_ld (0 = never).
    always begin
        @(posedge clk);
        #1;
        if (enc_ld) begin
            enc_cnt  = enc_lat;
            done_int = 1'b0;
        end else if (enc_cnt > 0) begin
            enc_cnt--;
            if (enc_cnt == 0) done_int = 1'b1;
        end
        fec_in   = enc_fn(frame);
        enc_done = done_int | force_done;
    end

    // One clock step; pops and checks the scoreboard when the output is consumed.
    task automatic step();
        logic [W:0] exp_v;
        @(negedge clk);
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: got id=%0d word=%h, required no output", out_id, fec_out);
            end else begin
                exp_v = sb_q.pop_front();
                if ({out_id, fec_out} !== exp_v) begin
                    failures++;
                    $display("FAIL sb_word: got %h, required %h", {out_id, fec_out}, exp_v);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; out_ready = 1'b0; force_done = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_valid(output int n, input int budget);
        n = 0;
        while (out_valid !== 1'b1 && n < budget) begin
            step();
            n++;
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: got %0d pending, required 0", name, sb_q.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({gnt0, gnt1, ser_start, enc_ld, busy, out_valid, out_id, err} !== 8'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b, required 00000000",
                     {gnt0, gnt1, ser_start, enc_ld, busy, out_valid, out_id, err});
        end
        checks++;
        if (frame !== '0) begin
            failures++; $display("FAIL reset_frame: got %h, required 0", frame);
        end
        checks++;
        if (fec_out !== '0) begin
            failures++; $display("FAIL reset_fec_out: got %h, required 0", fec_out);
        end
    endtask

    task automatic test_single_frame();
        logic [BITS-1:0] d;
        int n;
        d = 48'hA5A5_0000_FFFF;
        do_reset();
        enc_lat = 50;
        step();
        sb_q.push_back({1'b0, enc_fn(d)});
        data0 = d; req0 = 1'b1;
        step();
        checks++;
        if ({gnt0, ser_start, enc_ld, gnt1} !== 4'b1110) begin
            failures++; $display("FAIL single_pulses: got %b, required 1110", {gnt0, ser_start, enc_ld, gnt1});
        end
        checks++;
        if (frame !== d) begin
            failures++; $display("FAIL single_frame: got %h, required %h", frame, d);
        end
        req0 = 1'b0;
        step();
        checks++;
        if ({gnt0, ser_start, enc_ld} !== 3'b000) begin
            failures++; $display("FAIL single_pulse_len: got %b, required 000", {gnt0, ser_start, enc_ld});
        end
        wait_valid(n, 200);
        n = n + 1;
        checks++;
        if (n != enc_lat + 1) begin
            failures++; $display("FAIL single_latency: got %0d, required %0d", n, enc_lat + 1);
        end
        checks++;
        if ({out_id, fec_out, busy} !== {1'b0, enc_fn(d), 1'b0}) begin
            failures++; $display("FAIL single_capture: got %h, required %h", {out_id, fec_out, busy}, {1'b0, enc_fn(d), 1'b0});
        end
        step(); step(); step();
        checks++;
        if (out_valid !== 1'b1) begin
            failures++; $display("FAIL single_hold: got %b, required 1", out_valid);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || fec_out !== enc_fn(d)) begin
            failures++; $display("FAIL single_pop: got valid=%b word=%h, required valid=0 word=%h", out_valid, fec_out, enc_fn(d));
        end
        drain("single");
    endtask

    task automatic test_round_robin();
        logic [BITS-1:0] d0 [2];
        logic [BITS-1:0] d1 [2];
        int g, g0, g1, cyc, last_cyc;
        d0[0] = 48'h0000_1111_2222; d0[1] = 48'h3333_4444_5555;
        d1[0] = 48'hAAAA_BBBB_CCCC; d1[1] = 48'hDDDD_EEEE_FFFF;
        do_reset();
        enc_lat = 4; out_ready = 1'b1;
        step();
        sb_q.push_back({1'b0, enc_fn(d0[0])});
        sb_q.push_back({1'b1, enc_fn(d1[0])});
        sb_q.push_back({1'b0, enc_fn(d0[1])});
        sb_q.push_back({1'b1, enc_fn(d1[1])});
        req0 = 1'b1; req1 = 1'b1; data0 = d0[0]; data1 = d1[0];
        g = 0; g0 = 0; g1 = 0; cyc = 0; last_cyc = 0;
        while (g < 4 && cyc < 300) begin
            step();
            cyc++;
            if (gnt0 || gnt1) begin
                checks++;
                if ({gnt1, gnt0} !== ((g % 2 == 1) ? 2'b10 : 2'b01)) begin
                    failures++; $display("FAIL rr_order: grant %0d got %b, required %b", g, {gnt1, gnt0}, (g % 2 == 1) ? 2'b10 : 2'b01);
                end
                if (g > 0) begin
                    checks++;
                    if (cyc - last_cyc != enc_lat + 2) begin
                        failures++; $display("FAIL rr_spacing: got %0d, required %0d", cyc - last_cyc, enc_lat + 2);
                    end
                end
                last_cyc = cyc;
                g++;
                if (gnt0) begin g0++; if (g0 < 2) data0 = d0[g0]; else req0 = 1'b0; end
                if (gnt1) begin g1++; if (g1 < 2) data1 = d1[g1]; else req1 = 1'b0; end
            end
        end
        checks++;
        if (g != 4) begin
            failures++; $display("FAIL rr_count: got %0d grants, required 4", g);
        end
        req0 = 1'b0; req1 = 1'b0;
        drain("rr");
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [BITS-1:0] a, b;
        int n;
        bit stray;
        a = 48'h1234_5678_9ABC; b = 48'hFEDC_BA98_7654;
        do_reset();
        enc_lat = 6; out_ready = 1'b0;
        step();
        sb_q.push_back({1'b0, enc_fn(a)});
        sb_q.push_back({1'b1, enc_fn(b)});
        req0 = 1'b1; req1 = 1'b1; data0 = a; data1 = b;
        step();
        checks++;
        if ({gnt1, gnt0} !== 2'b01) begin
            failures++; $display("FAIL bp_first: got %b, required 01", {gnt1, gnt0});
        end
        req0 = 1'b0;
        wait_valid(n, 100);
        stray = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (gnt1 !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b1) stray = 1'b1;
        end
        checks++;
        if (stray) begin
            failures++; $display("FAIL bp_stall: got grant/busy/valid change during stall, required none");
        end
        out_ready = 1'b1;
        step();
        checks++;
        if ({gnt1, out_valid} !== 2'b10) begin
            failures++; $display("FAIL bp_release: got gnt1,valid=%b, required 10", {gnt1, out_valid});
        end
        req1 = 1'b0; out_ready = 1'b0;
        wait_valid(n, 100);
        checks++;
        if (n != enc_lat + 1) begin
            failures++; $display("FAIL bp_relatency: got %0d, required %0d", n, enc_lat + 1);
        end
        out_ready = 1'b1;
        drain("bp");
        out_ready = 1'b0;
    endtask

    task automatic test_stale_done();
        logic [BITS-1:0] c;
        bit stray;
        c = 48'h0F1E_2D3C_4B5A;
        do_reset();
        out_ready = 1'b1; force_done = 1'b1;
        stray = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (out_valid !== 1'b0 || busy !== 1'b0) stray = 1'b1;
        end
        checks++;
        if (stray) begin
            failures++; $display("FAIL stale_idle: got capture in IDLE, required none");
        end
        sb_q.push_back({1'b1, enc_fn(c)});
        req1 = 1'b1; data1 = c;
        step();
        req1 = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL stale_load: got valid=%b, required 0", out_valid);
        end
        step();
        checks++;
        if ({out_valid, out_id, fec_out} !== {1'b1, 1'b1, enc_fn(c)}) begin
            failures++; $display("FAIL stale_run: got %h, required %h", {out_valid, out_id, fec_out}, {1'b1, 1'b1, enc_fn(c)});
        end
        force_done = 1'b0;
        drain("stale");
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        bit stray;
        do_reset();
        enc_lat = 50; out_ready = 1'b1;
        step();
        req0 = 1'b1; data0 = 48'hCAFE_F00D_BEEF;
        step();
        req0 = 1'b0;
        for (int i = 0; i < 20; i++) step();
        rst = 1'b1; req1 = 1'b1;
        step();
        checks++;
        if ({busy, out_valid, err, gnt0, gnt1} !== 5'b0) begin
            failures++; $display("FAIL rst_mid: got %b, required 00000", {busy, out_valid, err, gnt0, gnt1});
        end
        rst = 1'b0; req1 = 1'b0;
        stray = 1'b0;
        for (int i = 0; i < 70; i++) begin
            step();
            if (out_valid !== 1'b0 || busy !== 1'b0) stray = 1'b1;
        end
        checks++;
        if (stray) begin
            failures++; $display("FAIL rst_stray: got output after abort, required none");
        end
        out_ready = 1'b0;
    endtask

`ifdef FEC_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        do_reset();
        enc_lat = 0; out_ready = 1'b1;
        step();
        req0 = 1'b1;
        step();
        req0 = 1'b0;
        n = 0;
        do begin step(); n++; end while (busy === 1'b1 && n < 200);
        checks++;
        if (n - 1 != 64 || err !== 1'b1 || out_valid !== 1'b0) begin
            failures++; $display("FAIL timeout: got run=%0d err=%b valid=%b, required run=64 err=1 valid=0", n - 1, err, out_valid);
        end
        enc_lat = 5;
        step();
        sb_q.push_back({1'b1, enc_fn(48'h5555_AAAA_1234)});
        req0 = 1'b1; req1 = 1'b1; data1 = 48'h5555_AAAA_1234;
        step();
        req0 = 1'b0; req1 = 1'b0;
        wait_valid(n, 100);
        checks++;
        if (out_valid !== 1'b1 || err !== 1'b1) begin
            failures++; $display("FAIL timeout_after: got valid=%b err=%b, required 1 1", out_valid, err);
        end
        drain("timeout");
        out_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_reset();
        test_round_robin();
        test_backpressure();
        test_stale_done();
        test_reset_mid_run();
`ifdef FEC_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        checks++;
        if (sb_q.size() != 0) begin
            failures++; $display("FAIL sb_final: got %0d pending, required 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

endmodule
